// File: rtl/ped_walk_ctrl.sv
// ped_walk_ctrl: per-axis pedestrian WALK/DON'T-WALK sequencing behind the vehicle lights, with sticky conflict fault.
module ped_walk_axis #(
    parameter int WALK_CYCLES = 10,
    parameter int FLASH_DIV   = 2,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             force_idle,
    input  logic             hold,
    input  logic [2:0]       light,
    input  logic             btn,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending
);
    localparam int FW = $clog2(FLASH_DIV + 1);
    typedef enum logic [1:0] {IDLE, WALK, FLASH} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    fl_q, fl_d;
    logic             dw_q, dw_d, pend_q, pend_d;
    logic [2:0]       prev_q;
    logic             go;
    always_comb begin
        go      = state_q == IDLE && light == 3'b100 && prev_q != 3'b100 && (pend_q || btn) && !force_idle;
        state_d = state_q;
        cnt_d   = '0;
        fl_d    = fl_q;
        dw_d    = dw_q;
        pend_d  = hold ? pend_q : (go ? 1'b0 : pend_q | btn);
        if (force_idle) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (go) begin
                    state_d = WALK;
                    cnt_d   = CNT_W'(WALK_CYCLES);
                end
                WALK: if (cnt_q == CNT_W'(1) || light != 3'b100) begin
                    state_d = FLASH;
                    fl_d    = FW'(1);
                    dw_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                FLASH: if (light == 3'b001) begin
                    state_d = IDLE;
                end else if (fl_q == FW'(FLASH_DIV)) begin
                    fl_d = FW'(1);
                    dw_d = ~dw_q;
                end else begin
                    fl_d = fl_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fl_q    <= '0;
            dw_q    <= 1'b0;
            pend_q  <= 1'b0;
            prev_q  <= 3'b001;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
            dw_q    <= dw_d;
            pend_q  <= pend_d;
            prev_q  <= light;
        end
    end
    assign walk        = state_q == WALK;
    assign dont_walk   = state_q == IDLE || (state_q == FLASH && dw_q);
    assign countdown   = cnt_q;
    assign req_pending = pend_q;
endmodule

module ped_walk_ctrl #(
    parameter int WALK_CYCLES = 10,
    parameter int FLASH_DIV   = 2,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ns_light,
    input  logic [2:0]       ew_light,
    input  logic             ns_btn,
    input  logic             ew_btn,
    output logic             ns_walk,
    output logic             ns_dont_walk,
    output logic             ew_walk,
    output logic             ew_dont_walk,
    output logic [CNT_W-1:0] ns_countdown,
    output logic [CNT_W-1:0] ew_countdown,
    output logic             ns_req_pending,
    output logic             ew_req_pending,
    output logic             fault
);
    logic fault_q, fault_d, bad;
    always_comb begin
        bad = !(ns_light inside {3'b100, 3'b010, 3'b001}) || !(ew_light inside {3'b100, 3'b010, 3'b001})
            || (ns_light != 3'b001 && ew_light != 3'b001);
        fault_d = fault_q | bad;
    end
    always_ff @(posedge clk) begin
        if (reset) fault_q <= 1'b0;
        else fault_q <= fault_d;
    end
    assign fault = fault_q;
    ped_walk_axis #(.WALK_CYCLES(WALK_CYCLES), .FLASH_DIV(FLASH_DIV), .CNT_W(CNT_W)) u_ns (
        .clk(clk), .reset(reset), .force_idle(fault_d), .hold(fault_q), .light(ns_light), .btn(ns_btn),
        .walk(ns_walk), .dont_walk(ns_dont_walk), .countdown(ns_countdown), .req_pending(ns_req_pending)
    );
    ped_walk_axis #(.WALK_CYCLES(WALK_CYCLES), .FLASH_DIV(FLASH_DIV), .CNT_W(CNT_W)) u_ew (
        .clk(clk), .reset(reset), .force_idle(fault_d), .hold(fault_q), .light(ew_light), .btn(ew_btn),
        .walk(ew_walk), .dont_walk(ew_dont_walk), .countdown(ew_countdown), .req_pending(ew_req_pending)
    );
endmodule

// File: doc/ped_walk_ctrl.md
Name: ped_walk_ctrl

Overview:
- Pedestrian signal stage directly downstream of the four-way vehicle light controller.
- Consumes the NS and EW vehicle light codes (3-bit one-hot: 100 green, 010 yellow, 001 red) and latches pedestrian push-button requests.
- Drives per-axis WALK / DON'T-WALK lamps with a walk countdown and a flashing clearance phase.
- Detects conflicting or invalid vehicle codes and forces a safe, sticky fault state.

Parameters:
- WALK_CYCLES, 10, number of cycles solid WALK is shown; legal range 1..2^CNT_W-1.
- FLASH_DIV, 2, half-period of flashing DON'T-WALK, in cycles; must be at least 1.
- CNT_W, 6, width of the countdown outputs and internal counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ns_light  in  3  NS vehicle light code, from north_light.
- ew_light  in  3  EW vehicle light code, from east_light.
- ns_btn  in  1  NS-crossing pedestrian button, level; any cycle high is a request.
- ew_btn  in  1  EW-crossing pedestrian button.
- ns_walk  out  1  NS WALK lamp.
- ns_dont_walk  out  1  NS DON'T-WALK lamp.
- ew_walk  out  1  EW WALK lamp.
- ew_dont_walk  out  1  EW DON'T-WALK lamp.
- ns_countdown  out  CNT_W  remaining NS walk cycles; 0 when not in WALK.
- ew_countdown  out  CNT_W  remaining EW walk cycles.
- ns_req_pending  out  1  NS request latched, not yet served.
- ew_req_pending  out  1  EW request latched, not yet served.
- fault  out  1  sticky conflict/invalid-code flag.

Behaviour:
- Reset and registering:
  - One clock; reset is synchronous and active-high. When reset is high at a clk edge, all registers are cleared.
  - Reset values: walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0, both axis FSMs in IDLE.
  - The previous-light registers reset to 001 (red). A green present on the first cycle after reset therefore counts as a green edge.
  - All outputs are registered (Moore, decoded from state registers).
- Axis FSM: two identical instances. The NS axis uses ns_light, ns_btn and the ns_* outputs; EW uses the ew_* set. States are IDLE, WALK, FLASH.
- IDLE:
  - Outputs: walk=0, dont_walk=1 solid, countdown=0.
  - A green edge is a cycle with light==100 and prev_light!=100.
  - On a green edge with (req_pending or btn) high, next state is WALK. The counter loads WALK_CYCLES and req_pending clears.
  - A button press in the same cycle as the green edge is therefore served.
- WALK:
  - Outputs: walk=1, dont_walk=0, countdown=counter. The counter decrements each cycle.
  - When counter==1, or light!=100, next state is FLASH. Walk lasts WALK_CYCLES cycles maximum; countdown shows WALK_CYCLES..1.
- FLASH:
  - Outputs: walk=0, countdown=0.
  - dont_walk is 1 for FLASH_DIV cycles, then 0 for FLASH_DIV cycles, repeating. The flash phase restarts (at 1) on each entry.
  - When light==001, next state is IDLE, with solid dont_walk on the following cycle.
- Request latch: btn high in any cycle not consumed by a WALK entry sets req_pending. Presses during WALK or FLASH are held for the next green; they do not extend the current walk.
- Fault detection:
  - Fault condition: either light code not in {100,010,001}, or (ns_light!=001 and ew_light!=001).
  - fault asserts on the cycle after the condition is sampled and stays set until reset.
  - While fault=1, both axes are forced to IDLE: walk=0, dont_walk=1 solid, countdown=0. req_pending holds its value but is never served.
  - Fault has priority over every FSM transition in the same cycle.
- Light sequences: lights skipping yellow (100 to 001) are legal. WALK goes to FLASH, then to IDLE one cycle later.
- Reset mid-operation: it overrides everything. Outputs take their reset values at the next clk edge.
- Counter width: no wrap-around. The counter is never decremented below 1 in WALK.

Test Plan:
- Reset held 2 cycles, then ns=100, ew=001 with no buttons: all dont_walk=1, walk=0, countdown=0, fault=0 indefinitely.
- ns_btn pulsed 1 cycle while ns=001, then ns goes 001→100 at cycle T (green held 31 cycles):
  - ns_req_pending=1 until T+1.
  - ns_walk=1 for T+1..T+10, with ns_countdown 10,9,..,1.
  - From T+11, ns_dont_walk follows 1,1,0,0,... until ns returns to 001, then solid 1 one cycle later.
- Green cut short (ns→010 at T+5): ns_walk drops at T+6, FLASH starts at T+6; ns_btn pressed at T+3 leaves ns_req_pending=1 and is served at the next NS green edge.
- ew_btn asserted in the same cycle as ew 001→100: ew_walk=1 the next cycle, ew_req_pending never rises.
- Conflict ns=100, ew=010 for 1 cycle in mid-WALK:
  - fault=1 the next cycle; all walk=0, dont_walk=1 solid.
  - Remains so after valid lights return; cleared only by reset.
  - Code 000 on ew_light gives the same result.
- Reset asserted at T+4 of an NS walk: next edge has ns_walk=0, ns_dont_walk=1, countdown=0, pending=0. ns already 100 after reset release gives a green edge, so a fresh ns_btn press is served immediately.
